// File: rtl/data_memory_ctrl_if.sv
// Load/store request and registered response bundle between the core and data_memory_ctrl.
interface data_memory_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// RV32I byte/half/word data memory with valid/ready handshake, programmable wait states,
// fault detection and a zero-clearing sweep after every reset.
module data_memory_ctrl #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  data_memory_ctrl_if.slave   bus,
  output logic                busy
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESP} state_t;

  state_t         state, state_nx;
  logic [AW-1:0]  clr_cnt;
  logic [2:0]     wcnt;
  logic [31:0]    mem [DEPTH];

  logic           we_p0;
  logic [2:0]     funct3_p0;
  logic [31:0]    addr_p0;
  logic [31:0]    wdata_p0;

  logic           cur_we;
  logic [2:0]     cur_funct3;
  logic [31:0]    cur_addr;
  logic [31:0]    cur_wdata;
  logic [AW-1:0]  cur_idx;
  logic           cur_fault;
  logic           accept;
  logic           enter_resp;
  logic [31:0]    rdata_p1;
  logic           fault_p1;

  function automatic logic access_fault(input logic we, input logic [2:0] f3,
                                        input logic [31:0] addr);
    logic bad;
    bad = (addr[31:AW+2] != '0);
    if (we && f3[2]) bad = 1'b1;
    case (f3[1:0])
      2'd0:    ;
      2'd1:    if (addr[0]) bad = 1'b1;
      2'd2:    if (addr[1:0] != 2'd0) bad = 1'b1;
      default: bad = 1'b1;
    endcase
    if (!we && f3 == 3'd6) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] off);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    return 32'(b);
      3'd1:    return 32'(h);
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] res;
    res = old;
    case (f3[1:0])
      2'd0:    res[8*off +: 8]       = wd[7:0];
      2'd1:    res[16*off[1] +: 16]  = wd[15:0];
      default: res                   = wd;
    endcase
    return res;
  endfunction

  assign accept = bus.req_valid && (state == S_IDLE);

  // With zero wait states the memory action happens on the acceptance edge itself,
  // so the live request is used instead of the latched copy.
  always_comb begin
    cur_we     = we_p0;
    cur_funct3 = funct3_p0;
    cur_addr   = addr_p0;
    cur_wdata  = wdata_p0;
    if (state == S_IDLE) begin
      cur_we     = bus.req_we;
      cur_funct3 = bus.req_funct3;
      cur_addr   = bus.req_addr;
      cur_wdata  = bus.req_wdata;
    end
  end

  assign cur_idx    = cur_addr[AW+1:2];
  assign cur_fault  = access_fault(cur_we, cur_funct3, cur_addr);
  assign enter_resp = (state_nx == S_RESP) && (state != S_RESP);

  always_comb begin
    state_nx = state;
    case (state)
      S_CLEAR: if (clr_cnt == AW'(DEPTH - 1)) state_nx = S_IDLE;
      S_IDLE:  if (accept) state_nx = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (wcnt == 3'd1) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_CLEAR;
      clr_cnt  <= '0;
      wcnt     <= '0;
      rdata_p1 <= '0;
      fault_p1 <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (accept)                wcnt <= 3'(WAIT_STATES);
      else if (state == S_WAIT)  wcnt <= wcnt - 3'd1;
      if (enter_resp) begin
        rdata_p1 <= (!cur_we && !cur_fault)
                    ? load_extend(mem[cur_idx], cur_funct3, cur_addr[1:0]) : 32'd0;
        fault_p1 <= cur_fault;
      end else if (state == S_RESP) begin
        rdata_p1 <= '0;
        fault_p1 <= 1'b0;
      end
    end
  end

  // p0: request captured at acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0     <= bus.req_we;
      funct3_p0 <= bus.req_funct3;
      addr_p0   <= bus.req_addr;
      wdata_p0  <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_CLEAR)
      mem[clr_cnt] <= '0;
    else if (enter_resp && cur_we && !cur_fault)
      mem[cur_idx] <= store_merge(mem[cur_idx], cur_wdata, cur_funct3, cur_addr[1:0]);
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_rdata = rdata_p1;
  assign bus.rsp_fault = fault_p1;
  assign busy          = (state == S_CLEAR);
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: three instances (0, 3 and 7 wait states) checked against
// directed vectors and a byte-level reference model under random stimulus.
module tb_data_memory_ctrl;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  f3 = 3'd0;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  int          sel = 0;

  logic        rdy [3];
  logic        rv  [3];
  logic        rf  [3];
  logic        bsy [3];
  logic [31:0] rd  [3];

  int tests = 0;
  int fails = 0;

  logic [7:0] mb [3][DEPTH*4];

  always #5 clk = ~clk;

  data_memory_ctrl_if i0 ();
  data_memory_ctrl_if i3 ();
  data_memory_ctrl_if i7 ();

  assign i0.req_valid = valid && (sel == 0);
  assign i3.req_valid = valid && (sel == 1);
  assign i7.req_valid = valid && (sel == 2);
  assign i0.req_we = we;  assign i3.req_we = we;  assign i7.req_we = we;
  assign i0.req_funct3 = f3;  assign i3.req_funct3 = f3;  assign i7.req_funct3 = f3;
  assign i0.req_addr = addr;  assign i3.req_addr = addr;  assign i7.req_addr = addr;
  assign i0.req_wdata = wd;  assign i3.req_wdata = wd;  assign i7.req_wdata = wd;

  assign rdy[0] = i0.req_ready;  assign rdy[1] = i3.req_ready;  assign rdy[2] = i7.req_ready;
  assign rv[0]  = i0.rsp_valid;  assign rv[1]  = i3.rsp_valid;  assign rv[2]  = i7.rsp_valid;
  assign rf[0]  = i0.rsp_fault;  assign rf[1]  = i3.rsp_fault;  assign rf[2]  = i7.rsp_fault;
  assign rd[0]  = i0.rsp_rdata;  assign rd[1]  = i3.rsp_rdata;  assign rd[2]  = i7.rsp_rdata;

  data_memory_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_w0 (.clk(clk), .rst_n(rst_n), .bus(i0), .busy(bsy[0]));
  data_memory_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_w3 (.clk(clk), .rst_n(rst_n), .bus(i3), .busy(bsy[1]));
  data_memory_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(7)) u_w7 (.clk(clk), .rst_n(rst_n), .bus(i7), .busy(bsy[2]));

  function automatic int ws(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 7;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 3; d++)
      for (int b = 0; b < DEPTH*4; b++) mb[d][b] = 8'h00;
  endtask

  // Reference: memory as a byte array, access legality and extension from plain arithmetic.
  task automatic model_op(input int d, input logic w, input logic [2:0] fn, input logic [31:0] a,
                          input logic [31:0] data, output logic [31:0] erd, output logic eflt);
    int unsigned size, base;
    logic legal;
    logic [31:0] val;
    size  = 1 << fn[1:0];
    legal = w ? (fn <= 3'd2) : (fn == 3'd0 || fn == 3'd1 || fn == 3'd2 || fn == 3'd4 || fn == 3'd5);
    eflt  = !legal || (a % size != 0) || (a / 4 >= DEPTH);
    erd   = '0;
    if (!eflt) begin
      base = a;
      if (w) begin
        for (int unsigned b = 0; b < size; b++) mb[d][base + b] = data[8*b +: 8];
      end else begin
        val = '0;
        for (int unsigned b = 0; b < size; b++) val = val | (32'(mb[d][base + b]) << (8*b));
        if (fn[2] == 1'b0 && size < 4 && val[8*size-1])
          val = val | ~((32'd1 << (8*size)) - 32'd1);
        erd = val;
      end
    end
  endtask

  // Called and returns at 1 time unit after a rising edge.
  task automatic do_access(input int d, input logic w, input logic [2:0] fn, input logic [31:0] a,
                           input logic [31:0] data, output logic [31:0] rdata, output logic flt,
                           output int lat);
    int n;
    n = 0;
    rdata = '0; flt = 1'b0; lat = -1;
    while (!rdy[d] && n < 200) begin @(posedge clk); #1; n++; end
    if (!rdy[d]) begin
      check("ready_wait", {31'd0, rdy[d]}, 32'd1);
      return;
    end
    sel = d; we = w; f3 = fn; addr = a; wd = data; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    addr = 32'hFFFF_FFFF; wd = 32'h5A5A_5A5A;
    lat = 1;
    while (!rv[d] && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!rv[d]) begin
      check("rsp_wait", {31'd0, rv[d]}, 32'd1);
      return;
    end
    rdata = rd[d];
    flt = rf[d];
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_f;
  } vec_t;

  vec_t vt [19];

  initial begin
    logic [31:0] grd, erd;
    logic gf, ef;
    int lat, cnt, r0, r1, v0, cyc;

    vt[0]  = '{1'b1, 3'd2, 32'h10,  32'h80FF7F01, 32'h00000000, 1'b0};
    vt[1]  = '{1'b0, 3'd0, 32'h13,  32'h0,        32'hFFFFFF80, 1'b0};
    vt[2]  = '{1'b0, 3'd4, 32'h13,  32'h0,        32'h00000080, 1'b0};
    vt[3]  = '{1'b0, 3'd1, 32'h10,  32'h0,        32'h00007F01, 1'b0};
    vt[4]  = '{1'b0, 3'd1, 32'h12,  32'h0,        32'hFFFF80FF, 1'b0};
    vt[5]  = '{1'b1, 3'd2, 32'h20,  32'h11223344, 32'h00000000, 1'b0};
    vt[6]  = '{1'b1, 3'd0, 32'h21,  32'hFFFFFFAA, 32'h00000000, 1'b0};
    vt[7]  = '{1'b1, 3'd1, 32'h22,  32'h1234BEEF, 32'h00000000, 1'b0};
    vt[8]  = '{1'b0, 3'd2, 32'h20,  32'h0,        32'hBEEFAA44, 1'b0};
    vt[9]  = '{1'b0, 3'd2, 32'h02,  32'h0,        32'h00000000, 1'b1};
    vt[10] = '{1'b1, 3'd1, 32'h05,  32'hFFFFFFFF, 32'h00000000, 1'b1};
    vt[11] = '{1'b0, 3'd3, 32'h10,  32'h0,        32'h00000000, 1'b1};
    vt[12] = '{1'b1, 3'd2, 32'h100, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vt[13] = '{1'b0, 3'd2, 32'h10,  32'h0,        32'h80FF7F01, 1'b0};
    vt[14] = '{1'b0, 3'd2, 32'h20,  32'h0,        32'hBEEFAA44, 1'b0};
    vt[15] = '{1'b0, 3'd2, 32'h00,  32'h0,        32'h00000000, 1'b0};
    vt[16] = '{1'b0, 3'd5, 32'h12,  32'h0,        32'h000080FF, 1'b0};
    vt[17] = '{1'b1, 3'd3, 32'h30,  32'hFFFFFFFF, 32'h00000000, 1'b1};
    vt[18] = '{1'b0, 3'd2, 32'h30,  32'h0,        32'h00000000, 1'b0};

    model_clear();
    #12;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_ready%0d", d), {31'd0, rdy[d]}, 32'd0);
      check($sformatf("reset_rsp_valid%0d", d), {31'd0, rv[d]}, 32'd0);
      check($sformatf("reset_rdata%0d", d), rd[d], 32'd0);
      check($sformatf("reset_fault%0d", d), {31'd0, rf[d]}, 32'd0);
      check($sformatf("reset_busy%0d", d), {31'd0, bsy[d]}, 32'd1);
    end

    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    while (bsy[1] && cnt < 200) begin @(posedge clk); #1; cnt++; end
    check("busy_cycles", cnt, DEPTH);
    check("ready_after_clear", {31'd0, rdy[1]}, 32'd1);

    for (int i = 0; i < DEPTH; i++) begin
      do_access(1, 1'b0, 3'd2, 32'(i*4), 32'h0, grd, gf, lat);
      check($sformatf("clear_word%0d", i), grd, 32'd0);
    end

    for (int i = 0; i < 19; i++) begin
      model_op(1, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd, erd, ef);
      do_access(1, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd, grd, gf, lat);
      check($sformatf("vec%0d_rdata", i), grd, vt[i].exp_rd);
      check($sformatf("vec%0d_fault", i), {31'd0, gf}, {31'd0, vt[i].exp_f});
      check($sformatf("vec%0d_latency", i), lat, 4);
    end

    // Response is a single-cycle pulse and its registers clear on the way out.
    @(posedge clk); #1;
    check("rsp_pulse_end", {31'd0, rv[1]}, 32'd0);
    check("rdata_cleared", rd[1], 32'd0);
    check("ready_after_rsp", {31'd0, rdy[1]}, 32'd1);

    for (int d = 0; d < 3; d++) begin
      sel = d; we = 1'b0; f3 = 3'd2; addr = 32'h0; wd = '0; valid = 1'b1;
      r0 = -1; r1 = -1; v0 = -1; cyc = 0;
      while (cyc < 60 && (r1 < 0 || v0 < 0)) begin
        if (rdy[d]) begin
          if (r0 < 0) r0 = cyc;
          else if (r1 < 0) r1 = cyc;
        end
        if (rv[d] && r0 >= 0 && v0 < 0) v0 = cyc;
        @(posedge clk); #1; cyc++;
      end
      valid = 1'b0;
      check($sformatf("held_latency_w%0d", ws(d)), v0 - r0, ws(d) + 1);
      check($sformatf("accept_spacing_w%0d", ws(d)), r1 - r0, ws(d) + 2);
    end

    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 120; i++) begin
        logic        w;
        logic [2:0]  fn;
        logic [31:0] a, data;
        w    = 1'($urandom % 2);
        fn   = 3'($urandom % 8);
        data = $urandom;
        if ($urandom % 8 < 5) a = $urandom_range(0, 63);
        else if ($urandom % 4 != 0) a = $urandom_range(0, DEPTH*4 + 7);
        else a = $urandom;
        model_op(d, w, fn, a, data, erd, ef);
        do_access(d, w, fn, a, data, grd, gf, lat);
        check($sformatf("rand_w%0d_%0d_rdata", ws(d), i), grd, erd);
        check($sformatf("rand_w%0d_%0d_fault", ws(d), i), {31'd0, gf}, {31'd0, ef});
        check($sformatf("rand_w%0d_%0d_latency", ws(d), i), lat, ws(d) + 1);
      end
    end

    // Reset arriving while a store is still waiting must cancel it.
    do_access(1, 1'b1, 3'd2, 32'h8, 32'h0BADF00D, grd, gf, lat);
    do_access(1, 1'b0, 3'd2, 32'h8, 32'h0, grd, gf, lat);
    check("pre_reset_word8", grd, 32'h0BADF00D);
    @(posedge clk); #1;
    sel = 1; we = 1'b1; f3 = 3'd2; addr = 32'h8; wd = 32'hDEADBEEF; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", {31'd0, bsy[1]}, 32'd1);
    check("midreset_ready", {31'd0, rdy[1]}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rv[1]) cnt++;
    end
    check("midreset_no_rsp", cnt, 0);
    rst_n = 1'b1;
    model_clear();
    cnt = 0;
    while (bsy[1] && cnt < 200) begin
      if (rv[1]) cnt = cnt + 1000;
      @(posedge clk); #1; cnt++;
    end
    check("midreset_clear_cycles", cnt, DEPTH);
    do_access(1, 1'b0, 3'd2, 32'h8, 32'h0, grd, gf, lat);
    check("midreset_word8", grd, 32'd0);
    check("midreset_word8_fault", {31'd0, gf}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised data memory for the RISC-V core, replacing the plain word-wide memory on the load/store path. Supports byte, halfword and word accesses selected by RV32I `funct3`, with sign/zero extension on loads and byte-lane masking on stores. Requests use a valid/ready handshake with a configurable number of wait states. Misaligned, out-of-range and illegal-size accesses are flagged as faults, and the array is zero-cleared by a hardware sweep after every reset.

## Interface
- `DEPTH`, 64: number of 32-bit words; power of two, ≥ 4.
- `WAIT_STATES`, 1: extra cycles between acceptance and response; legal range 0..7.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request.
- `req_we` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RV32I access size/sign code.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data; the low byte/half/word is used.
- `rsp_valid` output 1: one-cycle response pulse.
- `rsp_rdata` output 32: load result; 0 for stores and faults.
- `rsp_fault` output 1: access rejected; qualified by `rsp_valid`.
- `busy` output 1: clear sweep in progress.

## Operation
- FSM states: CLEAR, IDLE, WAIT, RESP.
- **CLEAR:** on each edge, write 0 to word `clr_cnt` and increment `clr_cnt`. After the edge that writes word DEPTH-1, go to IDLE. `busy`=1 throughout.
- **IDLE:** `req_ready`=1. Acceptance is `req_valid && req_ready` at an edge.
  - On acceptance, latch `we`, `funct3`, `addr` and `wdata`, then load the wait counter.
  - Go to WAIT if `WAIT_STATES`>0, otherwise go to RESP.
- **WAIT:** decrement the counter each edge. Go to RESP on the edge where it reaches 0. `req_ready`=0.
- **RESP:** `rsp_valid`=1 for exactly one cycle, then go to IDLE. At most one request is outstanding.
- **Memory action:** performed on the edge that enters RESP.
  - A store writes its masked lanes.
  - A load registers extended data into `rsp_rdata`.
  - A store followed by a load to the same word returns the new data.
- **Loads:**
  - LB=0 and LH=1 sign-extend; LW=2; LBU=4 and LHU=5 zero-extend.
  - The byte is selected by `addr[1:0]`; the half is selected by `addr[1]`.
- **Stores:**
  - SB=0 writes lane `addr[1:0]` from `wdata[7:0]`.
  - SH=1 writes lanes {`addr[1]`*2, +1} from `wdata[15:0]`.
  - SW=2 writes all four lanes.
  - Unselected lanes are unchanged.
- **Fault** is raised by any of the following:
  - Half access with `addr[0]`=1.
  - Word access with `addr[1:0]`≠0.
  - Load with `funct3` ∈ {3,6,7}.
  - Store with `funct3`>2.
  - `addr[31:2]` ≥ DEPTH.
- **On fault:** no write, `rsp_rdata`=0, `rsp_fault`=1. Latency is identical to a normal access.
- The word index is `addr[31:2]`; there is no wrap-around, since out-of-range is a fault.

## Timing
- **Reset values:** `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_fault`=0, `busy`=1, state=CLEAR, `clr_cnt`=0.
- **Reset asserted mid-operation:**
  - Immediately drops any pending request with no response.
  - Restarts the clear sweep.
  - Blocks partially waited stores, which never write.
- **Clear duration:** `busy` falls and `req_ready` rises DEPTH cycles after the first edge with `rst_n`=1.
- **Latency:** acceptance at edge k gives `rsp_valid` high in the cycle after edge k+`WAIT_STATES`, i.e. `WAIT_STATES`+1 cycles.
- **Throughput:** `req_ready` is low from the acceptance edge until the cycle after `rsp_valid`. Back-to-back throughput is therefore one access per `WAIT_STATES`+2 cycles.
- **Output registering:** `rsp_rdata` and `rsp_fault` are registered, stable only while `rsp_valid`=1, and cleared to 0 on the edge leaving RESP.
- **Request inputs:** sampled only at acceptance. Changes while `req_ready`=0 are ignored.

## Test plan
- **Reset clear:** DEPTH=64; release `rst_n`, count cycles → `busy` high for exactly 64 cycles. An LW of every word then returns 0x00000000.
- **Byte/half extension:**
  - Setup: SW 0x80FF7F01 @0x10.
  - LB @0x13 → 0xFFFFFF80; LBU @0x13 → 0x00000080.
  - LH @0x10 → 0x00007F01; LH @0x12 → 0xFFFF80FF.
- **Lane masking:** SW 0x11223344 @0x20, SB 0xAA @0x21, SH 0xBEEF @0x22, then LW @0x20 → 0xBEEFAA44.
- **Faults:**
  - LW @0x02, SH @0x05, load `funct3`=3, and SW @(DEPTH*4) each → `rsp_fault`=1, `rsp_rdata`=0.
  - Memory is unchanged afterwards.
- **Latency sweep:** for `WAIT_STATES`=0, 3 and 7, hold `req_valid` high continuously → `rsp_valid` arrives 1, 4 and 8 cycles after acceptance. The acceptance spacing is `WAIT_STATES`+2.
- **Reset mid-access:** with `WAIT_STATES`=3, SW 0xDEADBEEF @0x8 and pull `rst_n` low during WAIT → no `rsp_valid`, `busy`=1. After the clear sweep, LW @0x8 → 0.
